// File: rtl/mul_iter_unit_pkg.sv
// Shared types and constants for the iterative multiplier.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mul_iter_unit_if.sv
// EX-stage multiplier bus: operation request from the pipeline, stall/product back.
interface mul_iter_unit_if
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH
);
   logic             start;
   logic             is_signed;
   logic [0:WIDTH-1] op_a;
   logic [0:WIDTH-1] op_b;
   logic             flush;
   logic             mul_stall;
   logic             done;
   logic [0:WIDTH-1] result;

   modport master (
      output start, is_signed, op_a, op_b, flush,
      input  mul_stall, done, result
   );

   modport slave (
      input  start, is_signed, op_a, op_b, flush,
      output mul_stall, done, result
   );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for the EX stage; holds the pipeline while busy
// and presents the low WIDTH bits of the signed/unsigned product for one cycle.
module mul_iter_unit
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH,
   parameter int unsigned STEP  = 1
) (
   input  logic            clock,
   input  logic            reset,
   mul_iter_unit_if.slave  bus
);

   localparam int unsigned N  = WIDTH / STEP;
   localparam int unsigned CW = cnt_width(N);

   mul_state_t       state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             sign_q,   sign_d;

   logic [WIDTH-1:0] a_val, b_val, a_mag, b_mag;
   logic [WIDTH-1:0] acc_step, final_val;
   logic             done_c;

   // Port bit 0 is the MSB; positional assignment lands it at the top of a descending vector.
   assign a_val = bus.op_a;
   assign b_val = bus.op_b;

   assign a_mag = (bus.is_signed && a_val[WIDTH-1]) ? ('0 - a_val) : a_val;
   assign b_mag = (bus.is_signed && b_val[WIDTH-1]) ? ('0 - b_val) : b_val;

   always_comb begin
      acc_step = acc_q;
      for (int unsigned i = 0; i < STEP; i++) begin
         if (mplier_q[i]) begin
            acc_step = acc_step + (mcand_q << i);
         end
      end
   end

   assign final_val = sign_q ? ('0 - acc_q) : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      result_d = result_q;
      done_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               sign_d   = bus.is_signed & (a_val[WIDTH-1] ^ b_val[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = CW'(N - 1);
               state_d  = BUSY;
            end
         end
         BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << STEP;
            mplier_d = mplier_q >> STEP;
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            done_c   = 1'b1;
            result_d = final_val;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.flush) begin
         state_d  = IDLE;
         done_c   = 1'b0;
         result_d = result_q;
      end
   end

   assign bus.mul_stall = ((state_q == IDLE && bus.start) || state_q == BUSY) && !bus.flush;
   assign bus.done      = done_c;
   // Product is visible in the DONE cycle itself, then held by result_q.
   assign bus.result    = done_c ? final_val : result_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         result_q <= result_d;
      end
   end

endmodule

// File: doc/mul_iter_unit.md
# mul_iter_unit

Iterative integer multiplier in the EX stage of the five-stage pipelined processor. It produces the `mul_stall` signal that freezes the IF/ID and ID/EX pipe registers. It also supplies the 32-bit product that the EX/MEM register captures. Multiply instructions spend N+1 cycles in EX while the operation runs; all other instructions pass through without stall.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `STEP`, 1: multiplier bits retired per cycle. Must divide `WIDTH`. N = `WIDTH`/`STEP`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  reset, synchronous and active-low. Reset acts at a rising `clock` edge while `reset`==0.
- `start`  in  1  EX holds a multiply instruction. Stays high while the pipeline is frozen on that instruction.
- `is_signed`  in  1  1 = two's-complement multiply, 0 = unsigned multiply.
- `op_a`  in  [0:WIDTH-1]  multiplicand. Bit 0 is the MSB.
- `op_b`  in  [0:WIDTH-1]  multiplier. Bit 0 is the MSB.
- `flush`  in  1  abort the current operation (branch or jump squash).
- `mul_stall`  out  1  freeze the upstream pipe registers.
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  [0:WIDTH-1]  low `WIDTH` bits of the product.

## Operation
- States: IDLE, BUSY, DONE. The state register, counter, accumulator and latched operands are all registered.
- IDLE, with `start`=1 and `flush`=0:
  - latch |op_a|, |op_b| and the product sign into the operand registers;
  - clear the accumulator;
  - load counter = N-1;
  - go to BUSY.
- The product sign is `is_signed` & (op_a[0] ^ op_b[0]). The magnitude of the most negative value (0x80000000) is 2^31, which fits as an unsigned 32-bit value.
- BUSY: each cycle, for each of the `STEP` least-significant multiplier bits that is 1, add the shifted multiplicand into the accumulator. Then shift the multiplier right and the multiplicand left by `STEP`. Only the low `WIDTH` bits are kept; overflow is discarded silently.
  - If counter==0, go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - `result` = accumulator, two's-complement negated if the sign is set;
  - `done`=1;
  - go to IDLE.
- `start` is ignored in BUSY and DONE. During DONE, `start` still refers to the same frozen instruction, so it must not retrigger the unit.
- `mul_stall` = ((IDLE & `start`) | BUSY) & ~`flush`. This is combinational because EX must be held in the same cycle the multiply is first seen. `mul_stall` is low in DONE, so the pipeline advances at the end of that cycle.
- `flush`=1 in any state: next state is IDLE, `done` stays 0, and `result` is unchanged.
- `result` is registered and holds its value until the next DONE.
- Reset (`reset`==0) dominates `flush` and `start`. After reset: state IDLE, counter 0, accumulator 0.

## Timing
- Reset values: `mul_stall`=0 (provided `start` is low), `done`=0, `result`=0.
- Multiply first seen in cycle 0: `mul_stall` is high in cycles 0..N, and `done` plus a valid `result` occur in cycle N+1.
  - With defaults this is 33 stall cycles, with the result in cycle 33.
  - With `STEP`=2 it is 17 stall cycles, with the result in cycle 17.
- Back-to-back multiplies: the second `start` is first seen in cycle N+2 (IDLE). There is no dead cycle beyond DONE.
- `flush` with `start` in IDLE: no operation starts, and `mul_stall`=0 in that cycle.
- Reset mid-BUSY: the unit is in IDLE in the next cycle, with no `done` pulse.

## Structure
- Package `mul_pkg`:
  - `mul_state_t` enum {IDLE, BUSY, DONE};
  - `MUL_WIDTH`=32 constant;
  - a counter-width function, clog2(N).
- No sub-module. The per-step add/shift is one combinational block inside `mul_iter_unit`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 and `op_a`=5, `op_b`=5 → `done`=0 and `result`=0 throughout. After release, the unit starts in IDLE, so `mul_stall`=1 in the first released cycle while `start` is still high.
- Unsigned 7×6 (`is_signed`=0), `start` held high from cycle 0 → `mul_stall`=1 in cycles 0–32; `done`=1 and `result`=42 in cycle 33; one pulse only.
- Signed results (`is_signed`=1):
  - -3×5 → `result`=0xFFFFFFF1;
  - 0x80000000×0xFFFFFFFF → `result`=0x80000000;
  - -4×-4 → `result`=16.
- Unsigned 0xFFFFFFFF×0xFFFFFFFF → `result`=0x00000001 (low word, overflow dropped).
- `flush` in cycle 10 of BUSY → `mul_stall`=0 in cycle 10; no `done`; `result` keeps its prior value. A new `start` in cycle 11 completes in cycle 44.
- Back-to-back multiplies 3×4 then 9×9:
  - `done` in cycles 33 and 67;
  - `result` = 12 and then 81;
  - `start` held high through cycle 33 causes no extra operation.
